ccu_ctrl_snoop_unit: RTL and testbench

- Downstream consumer of the CCU control decoder's snoop-unit request (`su_valid`/`su_op`).
- Serves read requests that hit in a peer cache: forwards the first error-free responder's CD-channel cache line to the initiator as AXI R beats with ACE IsShared/PassDirty flags.
- Drains CD data from all other responders that announced a data transfer.
- Issues the single-beat invalidate acknowledge for CleanUnique/locked reads.

---
 rtl/ccu_ctrl_snoop_unit.sv | 215 +++++++++++++++++++++
 tb/tb_ccu_ctrl_snoop_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccu_ctrl_snoop_unit.sv
// Snoop unit: forwards the first responder's CD line as AXI R beats, drains the other responders, issues invalidate acks.
// Optional CCU_SU_LAST_CHECK_EN: checks cd_last_i against the beat counter and flags SLVERR on mismatch.
package ccu_ctrl_snoop_unit_pkg;
  typedef enum logic {READ_SNP_DATA = 1'b0, SEND_INVALID_ACK_R = 1'b1} su_op_e;
endpackage

module ccu_ctrl_snoop_unit
  import ccu_ctrl_snoop_unit_pkg::*;
#(
  parameter int unsigned DcacheLineWidth = 128,
  parameter int unsigned AxiDataWidth    = 32,
  parameter int unsigned AxiIdWidth      = 4,
  parameter int unsigned NoMstPorts      = 4,
  localparam int unsigned MstIdxBits     = $clog2(NoMstPorts)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               su_valid_i,
  output logic                               su_ready_o,
  input  su_op_e                             su_op_i,
  input  logic [AxiIdWidth-1:0]              ar_id_i,
  input  logic                               shared_i,
  input  logic                               dirty_i,
  input  logic [NoMstPorts-1:0]              data_available_i,
  input  logic [MstIdxBits-1:0]              first_responder_i,
  input  logic [NoMstPorts-1:0]              cd_valid_i,
  output logic [NoMstPorts-1:0]              cd_ready_o,
  input  logic [NoMstPorts*AxiDataWidth-1:0] cd_data_i,
  input  logic [NoMstPorts-1:0]              cd_last_i,
  output logic                               r_valid_o,
  input  logic                               r_ready_i,
  output logic [AxiIdWidth-1:0]              r_id_o,
  output logic [AxiDataWidth-1:0]            r_data_o,
  output logic [3:0]                         r_resp_o,
  output logic                               r_last_o,
  output logic                               busy_o
);

  localparam int unsigned DcacheLineWords = DcacheLineWidth / AxiDataWidth;
  localparam int unsigned CntW = (DcacheLineWords > 1) ? $clog2(DcacheLineWords) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(DcacheLineWords - 1);

  typedef enum logic [1:0] {IDLE, FWD, ACK} state_e;

  state_e                  state_q, state_d;
  logic [AxiIdWidth-1:0]   id_q, id_d;
  logic                    shared_q, shared_d;
  logic                    dirty_q, dirty_d;
  logic [NoMstPorts-1:0]   avail_q, avail_d;
  logic [MstIdxBits-1:0]   first_q, first_d;
  logic [CntW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [NoMstPorts-1:0]   done_q, done_d;
  logic [CntW-1:0]         drain_cnt_q [NoMstPorts];
  logic [CntW-1:0]         drain_cnt_d [NoMstPorts];

  logic [AxiDataWidth-1:0] cd_data_arr [NoMstPorts];
  logic                    fwd_vld, fwd_hs, fwd_last;
  logic [1:0]              resp_lo;
  logic                    unused_last;

  always_comb begin
    for (int j = 0; j < NoMstPorts; j++) begin
      cd_data_arr[j] = cd_data_i[j*AxiDataWidth +: AxiDataWidth];
    end
  end

  assign fwd_last = (beat_cnt_q == LastBeat);
  assign fwd_vld  = (state_q == FWD) && cd_valid_i[first_q] && !done_q[first_q];
  assign fwd_hs   = fwd_vld && r_ready_i;
  // Drain ports always stop at the counter boundary, so their cd_last bits never change behaviour.
  assign unused_last = ^cd_last_i;

`ifdef CCU_SU_LAST_CHECK_EN
  logic err_q, err_d;
  logic last_err, err_now;

  assign last_err = fwd_vld && (cd_last_i[first_q] != fwd_last);
  assign err_now  = err_q || last_err;
  assign resp_lo  = err_now ? 2'b10 : 2'b00;

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && su_valid_i) begin
      err_d = 1'b0;
    end else if (fwd_hs && last_err) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign resp_lo = 2'b00;
`endif

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    shared_d    = shared_q;
    dirty_d     = dirty_q;
    avail_d     = avail_q;
    first_d     = first_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = done_q;
    drain_cnt_d = drain_cnt_q;
    su_ready_o  = 1'b0;
    busy_o      = (state_q != IDLE);
    cd_ready_o  = '0;
    r_valid_o   = 1'b0;
    r_id_o      = '0;
    r_data_o    = '0;
    r_resp_o    = '0;
    r_last_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        su_ready_o = 1'b1;
        if (su_valid_i) begin
          id_d       = ar_id_i;
          shared_d   = shared_i;
          dirty_d    = dirty_i;
          avail_d    = data_available_i;
          first_d    = first_responder_i;
          beat_cnt_d = '0;
          // Ports with nothing to send start out finished.
          done_d     = ~data_available_i;
          for (int j = 0; j < NoMstPorts; j++) begin
            drain_cnt_d[j] = '0;
          end
          state_d = (su_op_i == READ_SNP_DATA) ? FWD : ACK;
        end
      end

      ACK: begin
        r_valid_o = 1'b1;
        r_id_o    = id_q;
        r_last_o  = 1'b1;
        if (r_ready_i) begin
          state_d = IDLE;
        end
      end

      FWD: begin
        r_valid_o = fwd_vld;
        r_id_o    = id_q;
        r_data_o  = cd_data_arr[first_q];
        r_resp_o  = {shared_q, dirty_q, resp_lo};
        r_last_o  = fwd_last;

        for (int j = 0; j < NoMstPorts; j++) begin
          if (MstIdxBits'(j) == first_q) begin
            cd_ready_o[j] = r_ready_i && !done_q[j];
          end else begin
            cd_ready_o[j] = avail_q[j] && !done_q[j];
            if (cd_valid_i[j] && cd_ready_o[j]) begin
              if (drain_cnt_q[j] == LastBeat) begin
                done_d[j]      = 1'b1;
                drain_cnt_d[j] = '0;
              end else begin
                drain_cnt_d[j] = drain_cnt_q[j] + 1'b1;
              end
            end
          end
        end

        if (fwd_hs) begin
          if (fwd_last) begin
            done_d[first_q] = 1'b1;
            beat_cnt_d      = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end

        if (&done_d) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      id_q       <= '0;
      shared_q   <= 1'b0;
      dirty_q    <= 1'b0;
      avail_q    <= '0;
      first_q    <= '0;
      beat_cnt_q <= '0;
      done_q     <= '0;
      for (int j = 0; j < NoMstPorts; j++) begin
        drain_cnt_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      shared_q    <= shared_d;
      dirty_q     <= dirty_d;
      avail_q     <= avail_d;
      first_q     <= first_d;
      beat_cnt_q  <= beat_cnt_d;
      done_q      <= done_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

endmodule

// File: tb/tb_ccu_ctrl_snoop_unit.sv
// Bench for ccu_ctrl_snoop_unit: directed and randomized requests with CD traffic, R beats checked by a scoreboard
// fed from a line-level model of what the initiator must see.
`timescale 1ns/1ps
module tb_ccu_ctrl_snoop_unit;
  import ccu_ctrl_snoop_unit_pkg::*;

  localparam int LW = 128;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int NP = 4;
  localparam int IB = 2;
  localparam int W  = LW / DW;
`ifdef CCU_SU_LAST_CHECK_EN
  localparam bit LastChk = 1'b1;
`else
  localparam bit LastChk = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n = 1'b1;
  logic           su_valid = 1'b0;
  logic           su_ready_o;
  su_op_e         su_op = READ_SNP_DATA;
  logic [IW-1:0]  ar_id = '0;
  logic           shared = 1'b0;
  logic           dirty = 1'b0;
  logic [NP-1:0]  data_available = '0;
  logic [IB-1:0]  first_responder = '0;
  logic [NP-1:0]  cd_valid = '0;
  logic [NP-1:0]  cd_ready_o;
  logic [NP*DW-1:0] cd_data = '0;
  logic [NP-1:0]  cd_last = '0;
  logic           r_valid_o;
  logic           r_ready = 1'b1;
  logic [IW-1:0]  r_id_o;
  logic [DW-1:0]  r_data_o;
  logic [3:0]     r_resp_o;
  logic           r_last_o;
  logic           busy_o;

  ccu_ctrl_snoop_unit #(
    .DcacheLineWidth(LW), .AxiDataWidth(DW), .AxiIdWidth(IW), .NoMstPorts(NP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .su_valid_i(su_valid), .su_ready_o(su_ready_o), .su_op_i(su_op),
    .ar_id_i(ar_id), .shared_i(shared), .dirty_i(dirty),
    .data_available_i(data_available), .first_responder_i(first_responder),
    .cd_valid_i(cd_valid), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data), .cd_last_i(cd_last),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o), .busy_o(busy_o)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] dat;
    logic [3:0]    resp;
    logic          last;
  } rbeat_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } cdb_t;

  rbeat_t exp_q[$];
  cdb_t   pq [NP][$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cnt = 0, acc_cyc = 0, last_hs_cyc = 0, rise_cyc = 0, rv_cycles = 0, r_hs_cnt = 0;
  int port_hs_cyc [NP];
  int rdy_mode = 0;
  bit gap_en = 1'b0;
  bit busy_s = 1'b0;
  bit prev_su_rdy = 1'b1;
  logic [NP-1:0] cdr_seen = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit pq_empty();
    for (int j = 0; j < NP; j++) if (pq[j].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Scoreboard monitor: every accepted R beat must match the next expected beat; stalled beats must hold.
  rbeat_t held;
  bit     stall_q = 1'b0;
  always @(negedge clk) begin
    rbeat_t cur, e;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      cur = {r_id_o, r_data_o, r_resp_o, r_last_o};
      if (stall_q) check("r_hold", cur, held);
      if (r_valid_o && r_ready) begin
        r_hs_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL r_unexpected: got beat %h with nothing expected", cur);
        end else begin
          e = exp_q.pop_front();
          check("r_beat", cur, e);
        end
      end
      stall_q = r_valid_o && !r_ready;
      held    = cur;
    end
  end

  task automatic tick();
    logic [NP-1:0] hs;
    cdb_t c;
    @(negedge clk);
    cyc++;
    hs = cd_valid & cd_ready_o;
    busy_s = busy_o;
    if (r_valid_o) rv_cycles++;
    cdr_seen = cdr_seen | cd_ready_o;
    if (su_valid && su_ready_o) begin acc_cnt++; acc_cyc = cyc; end
    if (hs != '0 || (r_valid_o && r_ready)) last_hs_cyc = cyc;
    if (su_ready_o && !prev_su_rdy) rise_cyc = cyc;
    prev_su_rdy = su_ready_o;
    for (int j = 0; j < NP; j++) begin
      if (hs[j] && pq[j].size() != 0) begin
        c = pq[j].pop_front();
        port_hs_cyc[j] = cyc;
      end
    end
    @(posedge clk);
    #1;
    for (int j = 0; j < NP; j++) begin
      if (!(cd_valid[j] && !hs[j])) begin
        if (pq[j].size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
          cd_valid[j] = 1'b1;
          cd_data[j*DW +: DW] = pq[j][0].d;
          cd_last[j] = pq[j][0].l;
        end else begin
          cd_valid[j] = 1'b0;
          cd_data[j*DW +: DW] = '0;
          cd_last[j] = 1'b0;
        end
      end
    end
    case (rdy_mode)
      0: r_ready = 1'b1;
      1: r_ready = ($urandom_range(0, 9) < 7);
      2: r_ready = !r_ready;
      default: r_ready = (rv_cycles >= 3);
    endcase
  endtask

  // Line-level model: the initiator sees the first responder's line verbatim, flags constant, SLVERR from the
  // first beat whose cd_last disagrees with its position (when the check is built in).
  task automatic model_push(su_op_e op, logic [IW-1:0] id, logic sh, logic dy, int f,
                            logic [NP-1:0] av, int bad_k, bit dbad);
    rbeat_t b;
    cdb_t   c;
    if (op == SEND_INVALID_ACK_R) begin
      b.id = id; b.dat = '0; b.resp = 4'b0000; b.last = 1'b1;
      exp_q.push_back(b);
      return;
    end
    for (int j = 0; j < NP; j++) begin
      if (av[j]) begin
        for (int k = 0; k < W; k++) begin
          c.d = $urandom;
          c.l = (k == W - 1);
          if (j == f && k == bad_k) c.l = !c.l;
          if (j != f && dbad && k == 0) c.l = !c.l;
          pq[j].push_back(c);
          if (j == f) begin
            b.id   = id;
            b.dat  = c.d;
            b.resp = {sh, dy, (LastChk && bad_k >= 0 && k >= bad_k) ? 2'b10 : 2'b00};
            b.last = (k == W - 1);
            exp_q.push_back(b);
          end
        end
      end
    end
  endtask

  task automatic drive_req(su_op_e op, logic [IW-1:0] id, logic sh, logic dy, int f, logic [NP-1:0] av);
    su_op = op; ar_id = id; shared = sh; dirty = dy;
    first_responder = IB'(f); data_available = av;
  endtask

  task automatic wait_accept(int n0);
    int t = 0;
    while (acc_cnt == n0 && t < 200) begin tick(); t++; end
    check("accept", acc_cnt != n0, 1);
  endtask

  task automatic issue(su_op_e op, logic [IW-1:0] id, logic sh, logic dy, int f,
                       logic [NP-1:0] av, int bad_k, bit dbad);
    int n0;
    model_push(op, id, sh, dy, f, av, bad_k, dbad);
    drive_req(op, id, sh, dy, f, av);
    n0 = acc_cnt;
    su_valid = 1'b1;
    wait_accept(n0);
    su_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    bit fin = 1'b0;
    while (!fin && t < 400) begin
      tick();
      t++;
      fin = !busy_s && exp_q.size() == 0 && pq_empty();
    end
    check("idle_reached", fin, 1);
    check("exit_timing", rise_cyc, last_hs_cyc + 1);
  endtask

  initial begin
    su_op_e        op;
    int            f, bk, n0, t;
    logic [NP-1:0] av;
    cdb_t          c;

    for (int j = 0; j < NP; j++) port_hs_cyc[j] = 0;
    #1 rst_n = 1'b0;
    #10;
    check("rst_su_ready", su_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_outputs", {cd_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Plain forward, no drain, full-rate R.
    rdy_mode = 0; r_ready = 1'b1;
    issue(READ_SNP_DATA, 4'hA, 1'b1, 1'b0, 2, 4'b0100, -1, 1'b0);
    wait_idle();

    // Forward with a concurrent drain while R toggles.
    rdy_mode = 2; r_ready = 1'b1;
    issue(READ_SNP_DATA, 4'h3, 1'b1, 1'b0, 2, 4'b0110, -1, 1'b0);
    wait_idle();
    check("drain_p1_cycles", port_hs_cyc[1] - acc_cyc, 4);

    // Invalidate ack held under three cycles of backpressure.
    rdy_mode = 3; r_ready = 1'b0; rv_cycles = 0; cdr_seen = '0;
    issue(SEND_INVALID_ACK_R, 4'h7, 1'b1, 1'b1, 1, 4'b1111, -1, 1'b0);
    wait_idle();
    check("ack_valid_cycles", rv_cycles, 4);
    check("ack_no_cd_ready", cdr_seen, 0);

    // Reset in the middle of a line.
    rdy_mode = 0; r_ready = 1'b1; r_hs_cnt = 0;
    issue(READ_SNP_DATA, 4'h9, 1'b0, 1'b1, 2, 4'b0100, -1, 1'b0);
    t = 0;
    while (r_hs_cnt < 2 && t < 100) begin tick(); t++; end
    check("mid_beats", r_hs_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_su_ready", su_ready_o, 1);
    check("midrst_busy", busy_o, 0);
    check("midrst_outputs", {cd_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o}, 0);
    exp_q.delete();
    for (int j = 0; j < NP; j++) while (pq[j].size() != 0) c = pq[j].pop_front();
    cd_valid = '0; cd_last = '0; cd_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    issue(READ_SNP_DATA, 4'h5, 1'b1, 1'b1, 2, 4'b0100, -1, 1'b0);
    wait_idle();

    // cd_last asserted early on the forwarded line.
    issue(READ_SNP_DATA, 4'hC, 1'b0, 1'b1, 1, 4'b0010, 1, 1'b0);
    wait_idle();

    // su_valid held across a forward: the second request is taken on the first IDLE cycle.
    model_push(READ_SNP_DATA, 4'h1, 1'b0, 1'b0, 3, 4'b1001, -1, 1'b0);
    model_push(READ_SNP_DATA, 4'h2, 1'b1, 1'b0, 3, 4'b1000, -1, 1'b0);
    drive_req(READ_SNP_DATA, 4'h1, 1'b0, 1'b0, 3, 4'b1001);
    n0 = acc_cnt;
    su_valid = 1'b1;
    wait_accept(n0);
    drive_req(READ_SNP_DATA, 4'h2, 1'b1, 1'b0, 3, 4'b1000);
    wait_accept(n0 + 1);
    su_valid = 1'b0;
    check("b2b_accept_cycle", acc_cyc, last_hs_cyc + 1);
    wait_idle();

    // Decoder misuse: first responder has no data; must still return to IDLE.
    issue(READ_SNP_DATA, 4'h6, 1'b0, 1'b0, 0, 4'b1010, -1, 1'b0);
    wait_idle();

    // Randomized traffic.
    rdy_mode = 1; gap_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 3) == 0) ? SEND_INVALID_ACK_R : READ_SNP_DATA;
      f  = $urandom_range(0, NP - 1);
      av = NP'($urandom_range(0, 15)) | (NP'(1) << f);
      bk = ($urandom_range(0, 4) == 0) ? $urandom_range(0, W - 1) : -1;
      issue(op, IW'($urandom), 1'($urandom), 1'($urandom), f, av, bk, 1'($urandom));
      wait_idle();
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
